// File: rtl/prog_loader.sv
// Byte-stream program loader: packs little-endian bytes into words, writes them to instruction memory and holds the core in reset until the load completes.
// Optional trailing checksum word (XOR of all data words) enabled with `define PROG_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module prog_loader #(
  parameter int ADDR_SIZE = 10,
  parameter int DATA_SIZE = 32
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 start,
  input  logic                 s_valid,
  input  logic [7:0]           s_data,
  output logic                 s_ready,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  output logic                 core_reset_n,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [ADDR_SIZE:0]   words_loaded
);

  localparam int BYTES = DATA_SIZE / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0]     LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [DATA_SIZE-1:0] MAX_WORDS = DATA_SIZE'(1) << ADDR_SIZE;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK   = 3'd4;
  localparam logic [2:0] S_END   = S_CHK;
`else
  localparam logic [2:0] S_END   = S_DONE;
`endif

  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_byte_cnt;
  logic [DATA_SIZE-1:0] r_word;
  logic [DATA_SIZE-1:0] r_hdr;
  logic                 r_s_ready;
  logic                 r_mem_we;
  logic [ADDR_SIZE-1:0] r_mem_addr;
  logic [DATA_SIZE-1:0] r_mem_wdata;
  logic                 r_core_rst_n;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;
  logic [ADDR_SIZE:0]   r_words_loaded;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_SIZE-1:0] r_xor;
`endif

  logic [2:0]           w_next;
  logic [DATA_SIZE-1:0] w_word;
  logic                 w_acc;
  logic                 w_last;
  logic                 w_final;
  logic                 w_enter_hdr;
  logic                 w_next_rdy;
  logic                 w_next_busy;

  assign w_acc       = s_valid && r_s_ready;
  assign w_last      = w_acc && (r_byte_cnt == LAST_BYTE);
  assign w_final     = (DATA_SIZE'(r_words_loaded) + DATA_SIZE'(1)) == r_hdr;
  assign w_enter_hdr = (w_next == S_HDR) && (r_state != S_HDR);

  // Incoming byte k of the current word lands in bits [8k+7:8k].
  always_comb begin
    w_word = r_word;
    w_word[{r_byte_cnt, 3'b000} +: 8] = s_data;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start) w_next = S_HDR;
      S_HDR: begin
        if (w_last) begin
          if (w_word == '0)            w_next = S_END;
          else if (w_word > MAX_WORDS) w_next = S_ERR;
          else                         w_next = S_LOAD;
        end
      end
      S_LOAD:  if (w_last) w_next = S_WRITE;
      S_WRITE: w_next = w_final ? S_END : S_LOAD;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK:   if (w_last) w_next = (w_word == r_xor) ? S_DONE : S_ERR;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_next_rdy  = (w_next == S_HDR) || (w_next == S_LOAD);
`ifdef PROG_LOADER_CHECKSUM_EN
    w_next_rdy  = w_next_rdy || (w_next == S_CHK);
`endif
    w_next_busy = !((w_next == S_IDLE) || (w_next == S_DONE) || (w_next == S_ERR));
  end

  // Status outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state        <= S_IDLE;
      r_byte_cnt     <= '0;
      r_word         <= '0;
      r_hdr          <= '0;
      r_s_ready      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_core_rst_n   <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_words_loaded <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_xor          <= '0;
`endif
    end else begin
      r_state      <= w_next;
      r_s_ready    <= w_next_rdy;
      r_busy       <= w_next_busy;
      r_done       <= (w_next == S_DONE);
      r_error      <= (w_next == S_ERR);
      r_core_rst_n <= (w_next == S_DONE);
      r_mem_we     <= (w_next == S_WRITE);
      if (w_enter_hdr) begin
        r_byte_cnt     <= '0;
        r_word         <= '0;
        r_words_loaded <= '0;
        r_mem_addr     <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        r_xor          <= '0;
`endif
      end else begin
        if (w_acc) begin
          r_word     <= w_word;
          r_byte_cnt <= w_last ? '0 : r_byte_cnt + 1'b1;
        end
        if ((r_state == S_HDR) && w_last) r_hdr <= w_word;
        // Address is captured only on entering WRITE so it never wraps after the last word.
        if ((r_state == S_LOAD) && w_last) begin
          r_mem_addr  <= r_words_loaded[ADDR_SIZE-1:0];
          r_mem_wdata <= w_word;
`ifdef PROG_LOADER_CHECKSUM_EN
          r_xor       <= r_xor ^ w_word;
`endif
        end
        if (r_state == S_WRITE) r_words_loaded <= r_words_loaded + 1'b1;
      end
    end
  end

  assign s_ready      = r_s_ready;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign core_reset_n = r_core_rst_n;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of complete loads plus hand sequences for latency, ignored start/bytes, full-depth load and mid-load reset.
`timescale 1ns/1ps
module tb_prog_loader;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          start;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          core_reset_n;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  always #5 CLK = ~CLK;

  prog_loader #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_reset_n(core_reset_n), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  typedef struct packed {
    logic [31:0]       n;
    logic [3:0][31:0]  w;
    logic [3:0]        nw;
    logic [3:0]        gap;
    logic              exp_done;
    logic              exp_err;
    logic [10:0]       exp_wl;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] tb_words [1024];
  logic [AW-1:0] wa_q [$];
  logic [DW-1:0] wd_q [$];
  vec_t vecs [8];

  always @(negedge CLK)
    if (RESET_N === 1'b1 && mem_we === 1'b1) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic st);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_data  = b;
    for (int c = 0; c < 50; c++) begin
      if (s_ready) begin
        start = st;
        ok = 1'b1;
        tick();
        start = 1'b0;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL byte_accept: s_ready stayed 0 for byte 0x%0h", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b0);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_load(input logic [31:0] n, input int nw, input int gap, input bit trailer);
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [31:0] x = '0;
`endif
    pulse_start();
    send_word(n);
    for (int i = 0; i < nw; i++) begin
`ifdef PROG_LOADER_CHECKSUM_EN
      x ^= tb_words[i];
`endif
      for (int k = 0; k < 4; k++) begin
        if (i == 0 && k == 2 && gap > 0) begin
          s_valid = 1'b0;
          repeat (gap) tick();
          chk("gap_s_ready", s_ready, 1);
          chk("gap_mem_we", mem_we, 0);
        end
        send_byte(tb_words[i][8*k +: 8], 1'b0);
      end
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    if (trailer) send_word(x);
`endif
    s_valid = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    for (int c = 0; c < budget; c++) begin
      if (done || error) break;
      tick();
    end
  endtask

  task automatic check_writes(input int nw);
    chk("write_count", wa_q.size(), nw);
    for (int i = 0; i < nw && i < wa_q.size(); i++) begin
      chk("write_addr", wa_q[i], i);
      chk("write_data", wd_q[i], tb_words[i]);
    end
  endtask

  task automatic clear_q;
    wa_q.delete();
    wd_q.delete();
  endtask

  function automatic vec_t mk(input logic [31:0] n, input int nw, input logic [31:0] w0,
                              input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3,
                              input int gap, input logic ed, input logic ee, input int wl);
    vec_t v;
    v.n = n; v.nw = 4'(nw); v.gap = 4'(gap);
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.exp_done = ed; v.exp_err = ee; v.exp_wl = 11'(wl);
    return v;
  endfunction

  initial begin
    int bad;
    vecs[0] = mk(32'd2, 2, 32'h00500013, 32'h00100093, 0, 0, 0, 1'b1, 1'b0, 2);
    vecs[1] = mk(32'd2, 2, 32'h00500013, 32'h00100093, 0, 0, 3, 1'b1, 1'b0, 2);
    vecs[2] = mk(32'd0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 0);
    vecs[3] = mk(32'h401, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1, 0);
    vecs[4] = mk(32'd3, 3, 32'hdeadbeef, 32'h12345678, 32'h00000000, 0, 0, 1'b1, 1'b0, 3);
    vecs[5] = mk(32'hffffffff, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1, 0);
    vecs[6] = mk(32'd1, 1, 32'ha5a5a5a5, 0, 0, 0, 1, 1'b1, 1'b0, 1);
    vecs[7] = mk(32'd4, 4, 32'h01020304, 32'hf0e0d0c0, 32'h80000001, 32'h7fffffff, 2, 1'b1, 1'b0, 4);

    RESET_N = 1'b0; start = 1'b0; s_valid = 1'b1; s_data = 8'hff;
    tick(); tick();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_core_reset_n", core_reset_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_words_loaded", words_loaded, 0);
    RESET_N = 1'b1;
    tick();
    chk("idle_s_ready", s_ready, 0);
    s_valid = 1'b0;

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 4; i++) tb_words[i] = vecs[v].w[i];
      clear_q();
      run_load(vecs[v].n, int'(vecs[v].nw), int'(vecs[v].gap), vecs[v].exp_done);
      wait_end(20);
      chk("vec_done", done, vecs[v].exp_done);
      chk("vec_error", error, vecs[v].exp_err);
      chk("vec_core_reset_n", core_reset_n, vecs[v].exp_done);
      chk("vec_words_loaded", words_loaded, vecs[v].exp_wl);
      chk("vec_busy", busy, 0);
      chk("vec_s_ready", s_ready, 0);
      check_writes(int'(vecs[v].nw));
    end

    // Write latency, then bytes offered while in DONE.
    clear_q();
    tb_words[0] = 32'h0badf00d;
    pulse_start();
    chk("hdr_busy", busy, 1);
    chk("hdr_s_ready", s_ready, 1);
    chk("hdr_done", done, 0);
    chk("hdr_core_reset_n", core_reset_n, 0);
    send_word(32'd1);
    send_byte(8'h0d, 1'b0); send_byte(8'hf0, 1'b0); send_byte(8'had, 1'b0);
    chk("lat_no_we_early", mem_we, 0);
    send_byte(8'h0b, 1'b0);
    chk("lat_mem_we", mem_we, 1);
    chk("lat_mem_addr", mem_addr, 0);
    chk("lat_mem_wdata", mem_wdata, 32'h0badf00d);
    chk("lat_s_ready_write", s_ready, 0);
    tick();
    chk("lat_we_one_cycle", mem_we, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_word(32'h0badf00d);
`endif
    s_valid = 1'b0;
    wait_end(20);
    chk("lat_done", done, 1);
    s_valid = 1'b1; s_data = 8'h77;
    repeat (3) tick();
    chk("done_s_ready", s_ready, 0);
    chk("done_hold", done, 1);
    chk("done_words_loaded", words_loaded, 1);
    chk("done_no_writes", wa_q.size(), 1);
    s_valid = 1'b0;

    // start while busy and start on the final byte are both ignored.
    clear_q();
    tb_words[0] = 32'h11223344; tb_words[1] = 32'h55667788;
    pulse_start();
    send_word(32'd2);
    send_byte(8'h44, 1'b1);
    send_byte(8'h33, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h11, 1'b0);
    send_byte(8'h88, 1'b0); send_byte(8'h77, 1'b0); send_byte(8'h66, 1'b0);
    send_byte(8'h55, 1'b1);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_word(32'h11223344 ^ 32'h55667788);
`endif
    s_valid = 1'b0;
    wait_end(20);
    chk("ign_done", done, 1);
    chk("ign_words_loaded", words_loaded, 2);
    check_writes(2);
    tick(); tick();
    chk("ign_still_done", done, 1);
    chk("ign_not_busy", busy, 0);

    // Full-depth load: N == 2^ADDR_SIZE.
    clear_q();
    for (int i = 0; i < 1024; i++) tb_words[i] = 32'(i) * 32'h9e3779b1;
    run_load(32'd1024, 1024, 0, 1'b1);
    wait_end(20);
    chk("full_done", done, 1);
    chk("full_error", error, 0);
    chk("full_words_loaded", words_loaded, 1024);
    chk("full_write_count", wa_q.size(), 1024);
    bad = 0;
    for (int i = 0; i < 1024 && i < wa_q.size(); i++)
      if (wa_q[i] !== AW'(i) || wd_q[i] !== tb_words[i]) bad++;
    chk("full_bad_writes", bad, 0);
    if (wa_q.size() == 1024) chk("full_last_addr", wa_q[1023], 1023);
    chk("full_mem_addr_hold", mem_addr, 1023);

`ifdef PROG_LOADER_CHECKSUM_EN
    clear_q();
    tb_words[0] = 32'h00500013; tb_words[1] = 32'h00100093;
    run_load(32'd2, 2, 0, 1'b0);
    s_valid = 1'b1;
    send_word(32'h00000000);
    s_valid = 1'b0;
    wait_end(20);
    chk("csum_bad_error", error, 1);
    chk("csum_bad_core_reset_n", core_reset_n, 0);
    chk("csum_bad_done", done, 0);
    clear_q();
    run_load(32'd2, 2, 0, 1'b0);
    send_word(32'h00400080);
    s_valid = 1'b0;
    wait_end(20);
    chk("csum_good_done", done, 1);
`endif

    // Reset asserted mid-load, then a fresh load from address 0.
    clear_q();
    tb_words[0] = 32'haaaa0001; tb_words[1] = 32'hbbbb0002;
    pulse_start();
    send_word(32'd4);
    send_word(32'haaaa0001);
    s_valid = 1'b0;
    tick();
    chk("mid_words_loaded", words_loaded, 1);
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_mem_wdata", mem_wdata, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_words_loaded", words_loaded, 0);
    chk("mid_rst_core_reset_n", core_reset_n, 0);
    tick();
    RESET_N = 1'b1;
    tick();
    clear_q();
    tb_words[0] = 32'hcafe0010; tb_words[1] = 32'hcafe0020;
    run_load(32'd2, 2, 0, 1'b1);
    wait_end(20);
    chk("reload_done", done, 1);
    chk("reload_words_loaded", words_loaded, 2);
    check_writes(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
